// File: rtl/shift_io_ctrl_pkg.sv
// Shared definitions for the shift/IO controller: shift-mode encodings.
package shift_io_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_SHL  = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_ROTL = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam int unsigned NUM_CHAN = 5;

endpackage

// File: rtl/shift_io_ctrl_input_cond_chan.sv
// One conditioning channel: 2-flop synchroniser, debounce counter, edge pulses.
module input_cond_chan #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic cond,
  output logic pos,
  output logic neg
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          cond_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cond   <= 1'b0;
      cond_q <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      cond_q <= cond;
      if (sync2 == cond) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cond <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Pulses cover the first cycle the new conditioned value is visible.
  assign pos = cond & ~cond_q;
  assign neg = ~cond & cond_q;

endmodule

// File: rtl/shift_io_ctrl.sv
// Conditioned-input shift register with shift/rotate modes, load, counter and LED window.
module shift_io_ctrl
  import shift_io_ctrl_pkg::*;
#(
  parameter int                 WIDTH           = 8,
  parameter int                 LED_W           = 4,
  parameter logic [WIDTH-1:0]   LOAD_VALUE      = WIDTH'(8'hA5),
  parameter int                 DEBOUNCE_CYCLES = 4,
  parameter int                 CNT_W           = 4,
  localparam int                NUM_WIN         = WIDTH / LED_W,
  localparam int                SEL_W           = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in_raw,
  input  logic             shift_raw,
  input  logic             load_raw,
  input  logic [1:0]       mode_raw,
  input  logic [SEL_W-1:0] led_sel,
  output logic [WIDTH-1:0] pout,
  output logic [LED_W-1:0] led,
  output logic             serial_out,
  output logic [CNT_W-1:0] shift_cnt
);

  logic [NUM_CHAN-1:0] raw_vec;
  logic [NUM_CHAN-1:0] cond_vec;
  logic [NUM_CHAN-1:0] pos_vec;
  logic [NUM_CHAN-1:0] neg_vec;

  assign raw_vec = {mode_raw, load_raw, shift_raw, ser_in_raw};

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
    input_cond_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_vec[g]),
      .cond  (cond_vec[g]),
      .pos   (pos_vec[g]),
      .neg   (neg_vec[g])
    );
  end

  logic       ser_in;
  logic       shift_p;
  logic       load_p;
  mode_e      mode;
  logic [WIDTH-1:0] shifted;

  assign ser_in  = cond_vec[0];
  assign shift_p = pos_vec[1];
  assign load_p  = neg_vec[2];
  assign mode    = mode_e'(cond_vec[4:3]);

  always_comb begin
    shifted = pout;
    case (mode)
      MODE_SHL:  shifted = {pout[WIDTH-2:0], ser_in};
      MODE_SHR:  shifted = {ser_in, pout[WIDTH-1:1]};
      MODE_ROTL: shifted = {pout[WIDTH-2:0], pout[WIDTH-1]};
      default:   shifted = pout;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pout      <= LOAD_VALUE;
      shift_cnt <= '0;
    end else if (load_p) begin
      pout      <= LOAD_VALUE;
      shift_cnt <= '0;
    end else if (shift_p && (mode != MODE_HOLD)) begin
      pout <= shifted;
      if (shift_cnt != '1) shift_cnt <= shift_cnt + 1'b1;
    end
  end

  // Out-of-range window index leaves led at zero.
  always_comb begin
    led = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      if (led_sel == SEL_W'(i)) led = pout[i*LED_W +: LED_W];
    end
  end

  assign serial_out = pout[WIDTH-1];

endmodule

// File: tb/tb_shift_io_ctrl.sv
// Directed self-checking bench for shift_io_ctrl (8-bit main instance, 12-bit LED-window instance).
module tb_shift_io_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_in_raw = 1'b0;
  logic       shift_raw = 1'b0;
  logic       load_raw = 1'b0;
  logic [1:0] mode_raw = 2'b00;
  logic       led_sel = 1'b1;
  logic [7:0] pout;
  logic [3:0] led;
  logic       serial_out;
  logic [3:0] shift_cnt;

  logic [1:0]  led_sel3 = 2'd0;
  logic [11:0] pout3;
  logic [3:0]  led3;
  logic        serial3;
  logic [3:0]  cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_io_ctrl #(
    .WIDTH           (8),
    .LED_W           (4),
    .LOAD_VALUE      (8'hA5),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (4)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_in_raw (ser_in_raw),
    .shift_raw  (shift_raw),
    .load_raw   (load_raw),
    .mode_raw   (mode_raw),
    .led_sel    (led_sel),
    .pout       (pout),
    .led        (led),
    .serial_out (serial_out),
    .shift_cnt  (shift_cnt)
  );

  shift_io_ctrl #(
    .WIDTH           (12),
    .LED_W           (4),
    .LOAD_VALUE      (12'hABC),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (4)
  ) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_in_raw (ser_in_raw),
    .shift_raw  (shift_raw),
    .load_raw   (load_raw),
    .mode_raw   (mode_raw),
    .led_sel    (led_sel3),
    .pout       (pout3),
    .led        (led3),
    .serial_out (serial3),
    .shift_cnt  (cnt3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_shift();
    shift_raw = 1'b1;
    tick(10);
    shift_raw = 1'b0;
    tick(10);
  endtask

  task automatic do_load();
    load_raw = 1'b1;
    tick(10);
    load_raw = 1'b0;
    tick(10);
  endtask

  task automatic set_mode(input logic [1:0] m, input logic s);
    mode_raw   = m;
    ser_in_raw = s;
    tick(10);
  endtask

  initial begin
    // 1: reset values
    tick(3);
    check("rst_pout", 32'(pout), 32'h A5);
    check("rst_led", 32'(led), 32'h A);
    check("rst_serial", 32'(serial_out), 32'h1);
    check("rst_cnt", 32'(shift_cnt), 32'h0);
    check("w12_led0", 32'(led3), 32'hC);
    led_sel3 = 2'd1; #1;
    check("w12_led1", 32'(led3), 32'hB);
    led_sel3 = 2'd2; #1;
    check("w12_led2", 32'(led3), 32'hA);
    led_sel3 = 2'd3; #1;
    check("w12_led_oor", 32'(led3), 32'h0);
    rst_n = 1'b1;
    tick(3);

    // 2: short glitch on shift is ignored
    shift_raw = 1'b1;
    tick(3);
    shift_raw = 1'b0;
    tick(12);
    check("glitch_pout", 32'(pout), 32'hA5);
    check("glitch_cnt", 32'(shift_cnt), 32'h0);

    // 3: shift left with exact latency, then other modes from A5
    shift_raw = 1'b1;
    tick(6);
    check("lat6_pout", 32'(pout), 32'hA5);
    tick(1);
    check("lat7_pout", 32'(pout), 32'h4A);
    check("shl_cnt", 32'(shift_cnt), 32'h1);
    check("shl_serial", 32'(serial_out), 32'h0);
    check("shl_led", 32'(led), 32'h4);
    shift_raw = 1'b0;
    tick(10);
    check("shl_release", 32'(pout), 32'h4A);

    do_load();
    check("load_pout", 32'(pout), 32'hA5);
    check("load_cnt", 32'(shift_cnt), 32'h0);
    set_mode(2'b01, 1'b1);
    press_shift();
    check("shr_pout", 32'(pout), 32'hD2);
    check("shr_cnt", 32'(shift_cnt), 32'h1);

    do_load();
    set_mode(2'b10, 1'b0);
    press_shift();
    check("rotl_pout", 32'(pout), 32'h4B);
    check("rotl_cnt", 32'(shift_cnt), 32'h1);

    do_load();
    set_mode(2'b11, 1'b0);
    press_shift();
    check("hold_pout", 32'(pout), 32'hA5);
    check("hold_cnt", 32'(shift_cnt), 32'h0);

    // 4: load release and shift press pulse on the same cycle
    set_mode(2'b10, 1'b0);
    press_shift();
    check("pre_coll_pout", 32'(pout), 32'h4B);
    load_raw = 1'b1;
    tick(10);
    check("load_held_pout", 32'(pout), 32'h4B);
    load_raw  = 1'b0;
    shift_raw = 1'b1;
    tick(10);
    check("coll_pout", 32'(pout), 32'hA5);
    check("coll_cnt", 32'(shift_cnt), 32'h0);
    shift_raw = 1'b0;
    tick(10);

    // 5: counter saturation over 20 rotates
    for (int i = 0; i < 20; i++) press_shift();
    check("sat_cnt", 32'(shift_cnt), 32'hF);
    check("sat_pout", 32'(pout), 32'h5A);
    led_sel = 1'b0; #1;
    check("sat_led0", 32'(led), 32'hA);
    led_sel = 1'b1; #1;
    check("sat_led1", 32'(led), 32'h5);

    // 6: reset mid-debounce discards the pending press
    shift_raw = 1'b1;
    tick(4);
    rst_n = 1'b0;
    tick(2);
    check("midrst_pout", 32'(pout), 32'hA5);
    check("midrst_cnt", 32'(shift_cnt), 32'h0);
    check("midrst_serial", 32'(serial_out), 32'h1);
    shift_raw = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(15);
    check("postrst_pout", 32'(pout), 32'hA5);
    check("postrst_cnt", 32'(shift_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
